uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver: 8 data bits LSB-first, 1 start, 1 stop, no parity.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame data width, counter sizing helper.
// Used by uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_START   = 3'd1,
        s_DATA    = 3'd2,
        s_STOP    = 3'd3,
        s_CLEANUP = 3'd4
    } uart_state_e;

    // Width of a counter that must hold 0..clks_per_bit-1 without wrapping.
    function automatic int uart_cnt_w(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for one asynchronous input; both flops preset to 1 so an
// idle-high line reads as idle straight out of reset.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Define UART_RX_MAJORITY_EN to decide every bit by a
// 2-of-3 vote around mid-bit (decision one cycle later); otherwise a single mid-bit sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam int CNT_W = uart_cnt_w(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam int MID   = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = MID + 1;
`else
    localparam int START_DEC = MID;
`endif
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DEC);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(UART_DATA_BITS - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic r_Rx;
    logic bit_val;

    uart_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]  byte_q, byte_d;
    logic                       dv_q, dv_d;
    logic                       ferr_q, ferr_d;
    logic                       active_q, active_d;

    uart_rx_sync u_sync (
        .clk_i  (i_Clock),
        .rst_ni (i_Rst_n),
        .d_i    (i_Rx_Serial),
        .q_o    (r_Rx)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is r_Rx one cycle ago, hist_q[1] two cycles ago; the vote at a decision
    // point therefore covers the sample before, at and after the nominal mid-bit.
    logic [1:0] hist_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], r_Rx};
        end
    end

    assign bit_val = maj3(hist_q[1], hist_q[0], r_Rx);
`else
    assign bit_val = r_Rx;
`endif

    // State register
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= s_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
        end
    end

    // Shift register is pure data; its content is only published after a good stop bit.
    always_ff @(posedge i_Clock) begin
        shift_q <= shift_d;
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;

        case (state_q)
            s_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!r_Rx) begin
                    state_d  = s_START;
                    active_d = 1'b1;
                end
            end

            s_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        state_d = s_DATA;
                    end else begin
                        state_d  = s_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            s_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = bit_val;
                    if (idx_q == IDX_LAST) begin
                        state_d = s_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            s_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = s_CLEANUP;
                    if (bit_val) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Holding here until the line is high keeps a break from decoding as 0x00 frames.
            s_CLEANUP: begin
                if (r_Rx) begin
                    state_d = s_IDLE;
                end
            end

            default: begin
                state_d = s_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        o_Rx_DV        = dv_q;
        o_Rx_Byte      = byte_q;
        o_Rx_Active    = active_q;
        o_Rx_Frame_Err = ferr_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 87 clocks per bit; build with UART_RX_MAJORITY_EN to
// include the spike-rejection scenario.
module tb_uart_rx;

    localparam int N = 87;
    localparam int M = (N - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT     = 4 + M + 9 * N + MAJ;
    localparam int ACT_LEN = 1 + M + 9 * N + MAJ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv;
    logic [7:0] rbyte;
    logic       active;
    logic       ferr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int ferr_cnt = 0;
    int act_cyc = 0;
    int viol = 0;
    int last_dv_cyc = 0;
    bit prev_strobe = 1'b0;
    logic [7:0] got_q[$];

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rbyte),
        .o_Rx_Active    (active),
        .o_Rx_Frame_Err (ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv) begin
            dv_cnt++;
            got_q.push_back(rbyte);
            last_dv_cyc = cyc;
        end
        if (ferr) ferr_cnt++;
        if (active) act_cyc++;
        if ((dv || ferr) && prev_strobe) viol++;
        if (dv && ferr) viol++;
        prev_strobe = dv || ferr;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit spike);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < N; j++) begin
                rx = (spike && j == M + 1) ? ~f[k] : f[k];
                tick();
            end
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", dv); end
        checks++; if (rbyte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", rbyte); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
        checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
        tick();
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_single();
        int dv0, f0, s;
        dv0 = dv_cnt;
        f0 = ferr_cnt;
        act_cyc = 0;
        s = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(30);
        checks++; if (dv_cnt !== dv0 + 1) begin failures++; $display("FAIL single_dv_count got=%0d exp=%0d", dv_cnt - dv0, 1); end
        checks++; if (rbyte !== 8'hA5) begin failures++; $display("FAIL single_byte got=%h exp=a5", rbyte); end
        checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt - f0); end
        checks++; if (last_dv_cyc - s !== LAT) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", last_dv_cyc - s, LAT); end
        checks++; if (act_cyc !== ACT_LEN) begin failures++; $display("FAIL single_active_len got=%0d exp=%0d", act_cyc, ACT_LEN); end
    endtask

    task automatic test_back_to_back();
        int dv0;
        logic [7:0] exp_b [3];
        logic [7:0] g;
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h3C;
        dv0 = dv_cnt;
        got_q.delete();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 1'b0);
        idle(20);
        checks++; if (dv_cnt !== dv0 + 3) begin failures++; $display("FAIL b2b_dv_count got=%0d exp=3", dv_cnt - dv0); end
        for (int i = 0; i < 3; i++) begin
            g = (got_q.size() > i) ? got_q[i] : 8'hxx;
            checks++; if (g !== exp_b[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, g, exp_b[i]); end
        end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL b2b_active_idle got=%b exp=0", active); end
    endtask

    task automatic test_glitch();
        int dv0, f0;
        idle(20);
        dv0 = dv_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (20) tick();
        rx = 1'b1;
        repeat (3 + M + MAJ - 20) @(posedge clk);
        @(negedge clk);
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL glitch_active_before got=%b exp=1", active); end
        @(negedge clk);
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL glitch_active_after got=%b exp=0", active); end
        tick();
        idle(100);
        checks++; if (dv_cnt !== dv0 || ferr_cnt !== f0) begin failures++; $display("FAIL glitch_strobe got_dv=%0d got_ferr=%0d exp=0", dv_cnt - dv0, ferr_cnt - f0); end
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(20);
        checks++; if (dv_cnt !== dv0 + 1 || rbyte !== 8'h5A) begin failures++; $display("FAIL glitch_next_byte got=%h n=%0d exp=5a n=1", rbyte, dv_cnt - dv0); end
    endtask

    task automatic test_frame_err();
        int dv0, f0;
        dv0 = dv_cnt;
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (2000) tick();
        checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
        checks++; if (dv_cnt !== dv0) begin failures++; $display("FAIL ferr_dv got=%0d exp=0", dv_cnt - dv0); end
        checks++; if (rbyte !== 8'h5A) begin failures++; $display("FAIL ferr_byte_held got=%h exp=5a", rbyte); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL ferr_active_break got=%b exp=0", active); end
        idle(100);
        checks++; if (ferr_cnt !== f0 + 1 || dv_cnt !== dv0) begin failures++; $display("FAIL ferr_after_break got_dv=%0d got_ferr=%0d exp_dv=0 exp_ferr=1", dv_cnt - dv0, ferr_cnt - f0); end
    endtask

    task automatic test_reset_midframe();
        int dv0, f0;
        logic [9:0] f;
        f = {1'b1, 8'h77, 1'b0};
        dv0 = dv_cnt;
        f0 = ferr_cnt;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!(k == 4 && j >= 40)) begin
                    rx = f[k];
                    tick();
                end
            end
        end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL rstmid_active_pre got=%b exp=1", active); end
        rst_n = 1'b0;
        #1;
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL rstmid_active got=%b exp=0", active); end
        checks++; if (rbyte !== 8'h00) begin failures++; $display("FAIL rstmid_byte got=%h exp=00", rbyte); end
        checks++; if (dv !== 1'b0 || ferr !== 1'b0) begin failures++; $display("FAIL rstmid_strobes got_dv=%b got_ferr=%b exp=0", dv, ferr); end
        repeat (5) tick();
        rx = 1'b1;
        tick();
        rst_n = 1'b1;
        idle(50);
        checks++; if (dv_cnt !== dv0 || ferr_cnt !== f0) begin failures++; $display("FAIL rstmid_no_strobe got_dv=%0d got_ferr=%0d exp=0", dv_cnt - dv0, ferr_cnt - f0); end
        send_frame(8'h12, 1'b1, 1'b0);
        idle(20);
        checks++; if (dv_cnt !== dv0 + 1) begin failures++; $display("FAIL rstmid_dv_count got=%0d exp=1", dv_cnt - dv0); end
        checks++; if (rbyte !== 8'h12) begin failures++; $display("FAIL rstmid_byte_after got=%h exp=12", rbyte); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        int dv0, f0;
        dv0 = dv_cnt;
        f0 = ferr_cnt;
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(20);
        checks++; if (dv_cnt !== dv0 + 1 || ferr_cnt !== f0) begin failures++; $display("FAIL maj_strobes got_dv=%0d got_ferr=%0d exp_dv=1 exp_ferr=0", dv_cnt - dv0, ferr_cnt - f0); end
        checks++; if (rbyte !== 8'hC3) begin failures++; $display("FAIL maj_byte got=%h exp=c3", rbyte); end
    endtask
`endif

    task automatic test_strobe_rules();
        checks++; if (viol !== 0) begin failures++; $display("FAIL strobe_rules got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        test_strobe_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
